// File: rtl/command_sequencer.sv
// Frame parser for the UART image pipeline: header/command decode, payload skid FIFO
// into the JPEG decoder, then filter and transmit handshakes.
module command_sequencer #(
  parameter logic [15:0] HEADER         = 16'hCDBA,
  parameter logic [7:0]  CMD_TAIL       = 8'hA0,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] dec_data,
  output logic       dec_valid,
  input  logic       dec_ready,
  input  logic       dec_done,
  output logic       flt_start,
  output logic [2:0] flt_mode,
  input  logic       flt_done,
  output logic       tx_start,
  output logic       tx_hist,
  input  logic       tx_done,
  output logic       busy,
  output logic       error
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {HDR0, HDR1, CMD0, CMD1, LOAD, FILT, SEND} state_t;

  state_t          state;
  logic [TW-1:0]   idle_cnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_cnt;

  logic hdr_hi, hdr_lo, cmd_ok, tail_ok, timeout;
  logic push, pop, full, wr_en, overflow, flush;

  assign hdr_hi  = (rx_data == HEADER[15:8]);
  assign hdr_lo  = (rx_data == HEADER[7:0]);
  assign cmd_ok  = (rx_data[7:4] >= 4'd1) && (rx_data[7:4] <= 4'd6) && (rx_data[3:0] == 4'd0);
  assign tail_ok = (rx_data == CMD_TAIL);
  assign timeout = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // FIFO control: a push into a full FIFO survives only if the head leaves the same cycle
  assign push     = (state == LOAD) && rx_valid;
  assign pop      = dec_valid && dec_ready;
  assign full     = (fifo_cnt == CW'(FIFO_DEPTH));
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign flush    = ((state == LOAD) && dec_done) || ((state == CMD1) && rx_valid && tail_ok);

  assign dec_valid = (fifo_cnt != '0);
  assign dec_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HDR0;
      idle_cnt  <= '0;
      busy      <= 1'b0;
      error     <= 1'b0;
      flt_start <= 1'b0;
      flt_mode  <= 3'd0;
      tx_start  <= 1'b0;
      tx_hist   <= 1'b0;
    end else begin
      error     <= 1'b0;
      flt_start <= 1'b0;
      tx_start  <= 1'b0;
      case (state)
        HDR0: begin
          idle_cnt <= '0;
          if (rx_valid && hdr_hi) begin
            state <= HDR1;
            busy  <= 1'b1;
          end
        end
        HDR1, CMD0, CMD1: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            case (state)
              HDR1: begin
                if (hdr_lo) state <= CMD0;
                else if (!hdr_hi) begin
                  state <= HDR0;
                  busy  <= 1'b0;
                end
              end
              CMD0: begin
                if (cmd_ok) begin
                  flt_mode <= rx_data[6:4];
                  state    <= CMD1;
                end else begin
                  error <= 1'b1;
                  state <= HDR0;
                  busy  <= 1'b0;
                end
              end
              CMD1: begin
                if (tail_ok) state <= LOAD;
                else begin
                  error    <= 1'b1;
                  state    <= HDR0;
                  busy     <= 1'b0;
                  flt_mode <= 3'd0;
                end
              end
              default: ;
            endcase
          end else if (timeout) begin
            idle_cnt <= '0;
            error    <= 1'b1;
            state    <= HDR0;
            busy     <= 1'b0;
            flt_mode <= 3'd0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        LOAD: begin
          if (dec_done) begin
            flt_start <= 1'b1;
            state     <= FILT;
          end else if (overflow) begin
            error <= 1'b1;
          end
        end
        FILT: begin
          if (flt_done) begin
            tx_start <= 1'b1;
            tx_hist  <= (flt_mode == 3'd4);
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_done) begin
            state    <= HDR0;
            busy     <= 1'b0;
            flt_mode <= 3'd0;
            tx_hist  <= 1'b0;
          end
        end
        default: begin
          state <= HDR0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
